stack_op_sequencer: RTL and testbench
=====================================

Name: stack_op_sequencer

Overview:
- Controller for the stack micro-op path. Accepts CALL, RET, INT and RTI requests from decode and arbitrates between them.
- Injects a fixed sequence of 16-bit stack micro-ops (push/pop PC halves, push/pop flags) into the decode stage. Holds fetch/decode stalled for the length of the sequence.
- Drives the PC-load request for CALL and INT targets. RET/RTI PC restore is performed by the memory stage from the popped data.

Parameters:
- PUSH_LO_OP, 16'h6008, push PC[15:0]
- PUSH_HI_OP, 16'h6009, push PC[31:16]
- POP_HI_OP, 16'h700A, pop PC[31:16]
- POP_LO_OP, 16'h700B, pop PC[15:0]
- PUSH_FL_OP, 16'h600C, push flags
- POP_FL_OP, 16'h700D, pop flags
- INT_VEC_BASE, 32'h0000_0002, INT target = INT_VEC_BASE + int_index
- DEPTH_W, 4, width of the optional call-depth counter

Ports:
- clk  in  1  clock, all state on posedge
- reset  in  1  asynchronous, active-high reset
- call_req  in  1  level; held by decode until accept
- ret_req  in  1  level; held until accept
- rti_req  in  1  level; held until accept
- int_req  in  1  single-cycle pulse, may arrive in any state
- int_index  in  2  vector index, sampled with int_req
- rdst_value  in  16  CALL target, sampled at CALL accept
- accept  out  1  one-cycle pulse: the request was taken
- int_ack  out  1  one-cycle pulse: the INT was taken
- inj_valid  out  1  inj_op is valid this cycle
- inj_op  out  16  injected micro-op; 16'h0000 when idle
- stall  out  1  freeze fetch/decode
- pc_load  out  1  load pc_target into the PC this cycle
- pc_target  out  32  CALL: {16'b0, latched rdst}; INT: vector address
- stack_err  out  1  only with the optional feature; constant 0 otherwise

Behaviour:
- All outputs are registered.
- Reset clears everything to 0 and the state to IDLE: stall, inj_valid, inj_op, pc_load, pc_target, accept, int_ack, int_pending and stack_err all become 0.
- Reset mid-sequence aborts the sequence immediately. No further ops are emitted after reset and no pc_load is issued.
- int_pending:
  - Set on an int_req pulse in any state; int_index is latched with it.
  - Cleared when the INT is accepted.
  - A second int_req while already pending is dropped and keeps the first index.
- Arbitration happens only in IDLE. Priority: int_pending > rti_req > call_req > ret_req.
- Requests that arrive while not IDLE wait; they stay held by the requester.
- On the accept edge: accept=1 (and int_ack=1 for INT), stall=1, inj_valid=1, and inj_op = the first op of the sequence. The operands are latched at this edge.
- States and sequences (one op per cycle):
  - CALL: PUSH_LO, PUSH_HI. pc_load=1 with pc_target={16'b0,rdst} during the PUSH_HI cycle.
  - RET: POP_HI, POP_LO. No pc_load.
  - INT: PUSH_FL, PUSH_LO, PUSH_HI. pc_load=1 with pc_target=INT_VEC_BASE+int_index during PUSH_HI.
  - RTI: POP_HI, POP_LO, POP_FL. No pc_load.
- After the last op the block returns to IDLE. It spends at least one cycle there with stall=0, inj_valid=0 and inj_op=0, so fetch always advances between sequences. The earliest next accept is therefore on the edge that leaves that IDLE cycle.
- Latency: accept edge to first op is 0 cycles (they share the edge). Sequence length is 2, 2, 3 and 3 cycles for CALL, RET, INT and RTI.
- accept, int_ack and pc_load are each high for exactly one cycle per sequence.
- pc_target holds its last value when pc_load=0.
- If several requests are presented together, only the highest-priority one is accepted. The others remain asserted and are served in later IDLE windows.

Optional Feature:
STACK_DEPTH_CHECK_EN
- Defined: a DEPTH_W-bit depth counter is maintained.
  - CALL and INT increment it; RET and RTI decrement it, applied at accept.
  - A RET or RTI presented in IDLE with depth=0 is not executed. The block pulses accept and sets stack_err=1 (sticky until reset). No ops are injected and stall stays 0.
  - At depth = all-ones, a CALL or INT still executes; the counter saturates and stack_err is set.
- Undefined: no counter; stack_err is tied to 0 and every request executes.

Test Plan:
- Reset is asserted mid-sequence -> all outputs go to 0 in the same cycle (asynchronous reset), and no pc_load follows.
- CALL with rdst_value=16'h1234 from IDLE -> accept pulse. inj_op sequence is 6008, 6009, then 0000. pc_load=1 with pc_target=32'h0000_1234 in the 6009 cycle. stall=1 for exactly 2 cycles.
- int_req pulse with int_index=2 arriving mid-CALL -> the CALL completes unchanged and one IDLE cycle follows. Then int_ack pulses and ops 600C, 6008, 6009 are emitted. pc_target=32'h0000_0004 is loaded on the 6009 cycle.
- call_req and ret_req asserted together and held -> CALL is served first, one IDLE cycle follows, then RET emits 700A, 700B with pc_load never asserted.
- RTI -> ops 700A, 700B, 700D; stall high for 3 cycles; then 0000.
- With STACK_DEPTH_CHECK_EN: RET issued straight after reset -> accept=1, stack_err=1, inj_valid stays 0. A subsequent CALL followed by RET runs normally and stack_err stays 1.

Source files
------------

// File: rtl/stack_op_sequencer_if.sv
// Decode-side handshake bundle for the stack micro-op sequencer.
// master = decode (drives requests), slave = sequencer (drives injected ops and PC load).
interface stack_op_sequencer_if;
  logic        call_req;
  logic        ret_req;
  logic        rti_req;
  logic        int_req;
  logic [1:0]  int_index;
  logic [15:0] rdst_value;
  logic        accept;
  logic        int_ack;
  logic        inj_valid;
  logic [15:0] inj_op;
  logic        stall;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        stack_err;

  modport master (
    output call_req, ret_req, rti_req, int_req, int_index, rdst_value,
    input  accept, int_ack, inj_valid, inj_op, stall, pc_load, pc_target, stack_err
  );

  modport slave (
    input  call_req, ret_req, rti_req, int_req, int_index, rdst_value,
    output accept, int_ack, inj_valid, inj_op, stall, pc_load, pc_target, stack_err
  );
endinterface

// File: rtl/stack_op_sequencer.sv
// Arbitrates CALL/RET/INT/RTI and injects the matching stack micro-op sequence into decode.
// Optional STACK_DEPTH_CHECK_EN adds a saturating call-depth counter driving a sticky stack_err.
module stack_op_sequencer #(
  parameter logic [15:0] PUSH_LO_OP   = 16'h6008,
  parameter logic [15:0] PUSH_HI_OP   = 16'h6009,
  parameter logic [15:0] POP_HI_OP    = 16'h700A,
  parameter logic [15:0] POP_LO_OP    = 16'h700B,
  parameter logic [15:0] PUSH_FL_OP   = 16'h600C,
  parameter logic [15:0] POP_FL_OP    = 16'h700D,
  parameter logic [31:0] INT_VEC_BASE = 32'h0000_0002,
  parameter int          DEPTH_W      = 4
) (
  input logic                 clk,
  input logic                 reset,
  stack_op_sequencer_if.slave bus
);

  // Each non-idle state names the op being emitted in that cycle.
  typedef enum logic [3:0] {
    IDLE, CALL_LO, CALL_HI, RET_HI, RET_LO,
    INT_FL, INT_LO, INT_HI, RTI_HI, RTI_LO, RTI_FL
  } state_t;

  state_t      state, state_nxt;
  logic        accept_q, accept_nxt;
  logic        int_ack_q, int_ack_nxt;
  logic        inj_valid_q, inj_valid_nxt;
  logic [15:0] inj_op_q, inj_op_nxt;
  logic        stall_q, stall_nxt;
  logic        pc_load_q, pc_load_nxt;
  logic [31:0] pc_target_q, pc_target_nxt;
  logic [31:0] target_q, target_nxt;
  logic        stack_err_q, stack_err_nxt;
  logic        int_pending;
  logic [1:0]  int_idx;
  logic        idle_ok, sel_int, sel_rti, sel_call, sel_ret;
  logic        pop_blocked, err_trip;

  // accept_q gating stops a still-held request being taken twice after an underflow accept.
  assign idle_ok  = (state == IDLE) && !accept_q;
  assign sel_int  = idle_ok && int_pending;
  assign sel_rti  = idle_ok && !int_pending && bus.rti_req;
  assign sel_call = idle_ok && !int_pending && !bus.rti_req && bus.call_req;
  assign sel_ret  = idle_ok && !int_pending && !bus.rti_req && !bus.call_req && bus.ret_req;

`ifdef STACK_DEPTH_CHECK_EN
  logic [DEPTH_W-1:0] depth;

  assign pop_blocked = (depth == '0);
  assign err_trip    = ((sel_ret || sel_rti) && (depth == '0)) ||
                       ((sel_call || sel_int) && (depth == '1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth <= '0;
    end else if (sel_call || sel_int) begin
      if (depth != '1) depth <= depth + 1'b1;
    end else if ((sel_ret || sel_rti) && (depth != '0)) begin
      depth <= depth - 1'b1;
    end
  end
`else
  logic [DEPTH_W-1:0] depth_unused;

  assign depth_unused = '0;
  assign pop_blocked  = 1'b0;
  assign err_trip     = 1'b0;
`endif

  // A pulse arriving while one is already pending is dropped, keeping the first index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_pending <= 1'b0;
      int_idx     <= 2'b00;
    end else if (sel_int) begin
      int_pending <= 1'b0;
    end else if (bus.int_req && !int_pending) begin
      int_pending <= 1'b1;
      int_idx     <= bus.int_index;
    end
  end

  always_comb begin
    state_nxt     = state;
    accept_nxt    = 1'b0;
    int_ack_nxt   = 1'b0;
    inj_op_nxt    = 16'h0000;
    pc_load_nxt   = 1'b0;
    pc_target_nxt = pc_target_q;
    target_nxt    = target_q;
    stack_err_nxt = stack_err_q | err_trip;

    case (state)
      IDLE: begin
        if (sel_int) begin
          accept_nxt  = 1'b1;
          int_ack_nxt = 1'b1;
          inj_op_nxt  = PUSH_FL_OP;
          target_nxt  = INT_VEC_BASE + {30'b0, int_idx};
          state_nxt   = INT_FL;
        end else if (sel_rti) begin
          accept_nxt = 1'b1;
          if (!pop_blocked) begin
            inj_op_nxt = POP_HI_OP;
            state_nxt  = RTI_HI;
          end
        end else if (sel_call) begin
          accept_nxt = 1'b1;
          inj_op_nxt = PUSH_LO_OP;
          target_nxt = {16'b0, bus.rdst_value};
          state_nxt  = CALL_LO;
        end else if (sel_ret) begin
          accept_nxt = 1'b1;
          if (!pop_blocked) begin
            inj_op_nxt = POP_HI_OP;
            state_nxt  = RET_HI;
          end
        end
      end
      CALL_LO: begin
        inj_op_nxt    = PUSH_HI_OP;
        pc_load_nxt   = 1'b1;
        pc_target_nxt = target_q;
        state_nxt     = CALL_HI;
      end
      RET_HI: begin
        inj_op_nxt = POP_LO_OP;
        state_nxt  = RET_LO;
      end
      INT_FL: begin
        inj_op_nxt = PUSH_LO_OP;
        state_nxt  = INT_LO;
      end
      INT_LO: begin
        inj_op_nxt    = PUSH_HI_OP;
        pc_load_nxt   = 1'b1;
        pc_target_nxt = target_q;
        state_nxt     = INT_HI;
      end
      RTI_HI: begin
        inj_op_nxt = POP_LO_OP;
        state_nxt  = RTI_LO;
      end
      RTI_LO: begin
        inj_op_nxt = POP_FL_OP;
        state_nxt  = RTI_FL;
      end
      default: state_nxt = IDLE;
    endcase

    inj_valid_nxt = (state_nxt != IDLE);
    stall_nxt     = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      accept_q    <= 1'b0;
      int_ack_q   <= 1'b0;
      inj_valid_q <= 1'b0;
      inj_op_q    <= 16'h0000;
      stall_q     <= 1'b0;
      pc_load_q   <= 1'b0;
      pc_target_q <= 32'h0;
      target_q    <= 32'h0;
      stack_err_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      accept_q    <= accept_nxt;
      int_ack_q   <= int_ack_nxt;
      inj_valid_q <= inj_valid_nxt;
      inj_op_q    <= inj_op_nxt;
      stall_q     <= stall_nxt;
      pc_load_q   <= pc_load_nxt;
      pc_target_q <= pc_target_nxt;
      target_q    <= target_nxt;
      stack_err_q <= stack_err_nxt;
    end
  end

  assign bus.accept    = accept_q;
  assign bus.int_ack   = int_ack_q;
  assign bus.inj_valid = inj_valid_q;
  assign bus.inj_op    = inj_op_q;
  assign bus.stall     = stall_q;
  assign bus.pc_load   = pc_load_q;
  assign bus.pc_target = pc_target_q;
  assign bus.stack_err = stack_err_q;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Directed bench for stack_op_sequencer; also covers STACK_DEPTH_CHECK_EN when that macro is defined.
module tb_stack_op_sequencer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic exp_err;

  stack_op_sequencer_if sif ();

  stack_op_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic call, input logic ret, input logic rti,
                               input logic intr, input logic [1:0] idx, input logic [15:0] rdst);
    sif.call_req   = call;
    sif.ret_req    = ret;
    sif.rti_req    = rti;
    sif.int_req    = intr;
    sif.int_index  = idx;
    sif.rdst_value = rdst;
  endtask

  task automatic checkField(input string tag, input string field,
                            input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic acc, input logic ack, input logic val,
                             input logic [15:0] op, input logic stl, input logic pcl,
                             input logic [31:0] tgt, input logic err);
    checkField(tag, "accept",    {31'b0, sif.accept},    {31'b0, acc});
    checkField(tag, "int_ack",   {31'b0, sif.int_ack},   {31'b0, ack});
    checkField(tag, "inj_valid", {31'b0, sif.inj_valid}, {31'b0, val});
    checkField(tag, "inj_op",    {16'b0, sif.inj_op},    {16'b0, op});
    checkField(tag, "stall",     {31'b0, sif.stall},     {31'b0, stl});
    checkField(tag, "pc_load",   {31'b0, sif.pc_load},   {31'b0, pcl});
    checkField(tag, "pc_target", sif.pc_target,          tgt);
    checkField(tag, "stack_err", {31'b0, sif.stack_err}, {31'b0, err});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
`ifdef STACK_DEPTH_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 2'd0, 16'h0000);
    tick();
    tick();
    checkOutput("reset", 0, 0, 0, 16'h0000, 0, 0, 32'h0, 0);
    reset = 1'b0;
    tick();
    checkOutput("idle", 0, 0, 0, 16'h0000, 0, 0, 32'h0, 0);

    // CALL 1234, with an INT (index 2) pulsed mid-sequence
    applyStimulus(1, 0, 0, 0, 2'd0, 16'h1234);
    tick();
    checkOutput("call_acc", 1, 0, 1, 16'h6008, 1, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 1, 2'd2, 16'h1234);
    tick();
    checkOutput("call_hi", 0, 0, 1, 16'h6009, 1, 1, 32'h0000_1234, 0);
    applyStimulus(0, 0, 0, 0, 2'd0, 16'h1234);
    tick();
    checkOutput("call_idle", 0, 0, 0, 16'h0000, 0, 0, 32'h0000_1234, 0);
    tick();
    checkOutput("int_acc", 1, 1, 1, 16'h600C, 1, 0, 32'h0000_1234, 0);
    tick();
    checkOutput("int_lo", 0, 0, 1, 16'h6008, 1, 0, 32'h0000_1234, 0);
    tick();
    checkOutput("int_hi", 0, 0, 1, 16'h6009, 1, 1, 32'h0000_0004, 0);

    // CALL and RET together: CALL first, then RET
    applyStimulus(1, 1, 0, 0, 2'd0, 16'hABCD);
    tick();
    checkOutput("int_idle", 0, 0, 0, 16'h0000, 0, 0, 32'h0000_0004, 0);
    tick();
    checkOutput("cr_call_acc", 1, 0, 1, 16'h6008, 1, 0, 32'h0000_0004, 0);
    applyStimulus(0, 1, 0, 0, 2'd0, 16'hABCD);
    tick();
    checkOutput("cr_call_hi", 0, 0, 1, 16'h6009, 1, 1, 32'h0000_ABCD, 0);
    tick();
    checkOutput("cr_idle", 0, 0, 0, 16'h0000, 0, 0, 32'h0000_ABCD, 0);
    tick();
    checkOutput("cr_ret_acc", 1, 0, 1, 16'h700A, 1, 0, 32'h0000_ABCD, 0);
    applyStimulus(0, 0, 0, 0, 2'd0, 16'hABCD);
    tick();
    checkOutput("cr_ret_lo", 0, 0, 1, 16'h700B, 1, 0, 32'h0000_ABCD, 0);
    tick();
    checkOutput("cr_ret_idle", 0, 0, 0, 16'h0000, 0, 0, 32'h0000_ABCD, 0);

    // RTI beats a held CALL; two INT pulses during RTI, the second is dropped
    applyStimulus(1, 0, 1, 0, 2'd0, 16'h5555);
    tick();
    checkOutput("rti_acc", 1, 0, 1, 16'h700A, 1, 0, 32'h0000_ABCD, 0);
    applyStimulus(1, 0, 0, 1, 2'd1, 16'h5555);
    tick();
    checkOutput("rti_lo", 0, 0, 1, 16'h700B, 1, 0, 32'h0000_ABCD, 0);
    applyStimulus(1, 0, 0, 1, 2'd3, 16'h5555);
    tick();
    checkOutput("rti_fl", 0, 0, 1, 16'h700D, 1, 0, 32'h0000_ABCD, 0);
    applyStimulus(1, 0, 0, 0, 2'd0, 16'h5555);
    tick();
    checkOutput("rti_idle", 0, 0, 0, 16'h0000, 0, 0, 32'h0000_ABCD, 0);
    tick();
    checkOutput("int2_acc", 1, 1, 1, 16'h600C, 1, 0, 32'h0000_ABCD, 0);
    tick();
    checkOutput("int2_lo", 0, 0, 1, 16'h6008, 1, 0, 32'h0000_ABCD, 0);
    tick();
    checkOutput("int2_hi", 0, 0, 1, 16'h6009, 1, 1, 32'h0000_0003, 0);
    tick();
    checkOutput("int2_idle", 0, 0, 0, 16'h0000, 0, 0, 32'h0000_0003, 0);
    tick();
    checkOutput("call2_acc", 1, 0, 1, 16'h6008, 1, 0, 32'h0000_0003, 0);
    applyStimulus(0, 0, 0, 0, 2'd0, 16'h5555);
    tick();
    checkOutput("call2_hi", 0, 0, 1, 16'h6009, 1, 1, 32'h0000_5555, 0);
    tick();
    checkOutput("call2_idle", 0, 0, 0, 16'h0000, 0, 0, 32'h0000_5555, 0);

    // Asynchronous reset in the middle of a CALL
    applyStimulus(1, 0, 0, 0, 2'd0, 16'h7777);
    tick();
    checkOutput("rst_call_acc", 1, 0, 1, 16'h6008, 1, 0, 32'h0000_5555, 0);
    applyStimulus(0, 0, 0, 0, 2'd0, 16'h7777);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_async", 0, 0, 0, 16'h0000, 0, 0, 32'h0, 0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("rst_after1", 0, 0, 0, 16'h0000, 0, 0, 32'h0, 0);
    tick();
    checkOutput("rst_after2", 0, 0, 0, 16'h0000, 0, 0, 32'h0, 0);

    // RET straight after reset: underflow when depth checking is built in
    applyStimulus(0, 1, 0, 0, 2'd0, 16'h0000);
    tick();
`ifdef STACK_DEPTH_CHECK_EN
    checkOutput("uf_acc", 1, 0, 0, 16'h0000, 0, 0, 32'h0, 1);
    applyStimulus(0, 0, 0, 0, 2'd0, 16'h0000);
    tick();
    checkOutput("uf_idle", 0, 0, 0, 16'h0000, 0, 0, 32'h0, 1);
`else
    checkOutput("uf_acc", 1, 0, 1, 16'h700A, 1, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 0, 2'd0, 16'h0000);
    tick();
    checkOutput("uf_lo", 0, 0, 1, 16'h700B, 1, 0, 32'h0, 0);
`endif
    tick();
    checkOutput("uf_done", 0, 0, 0, 16'h0000, 0, 0, 32'h0, exp_err);

    applyStimulus(1, 0, 0, 0, 2'd0, 16'h0042);
    tick();
    checkOutput("d_call_acc", 1, 0, 1, 16'h6008, 1, 0, 32'h0, exp_err);
    applyStimulus(0, 0, 0, 0, 2'd0, 16'h0042);
    tick();
    checkOutput("d_call_hi", 0, 0, 1, 16'h6009, 1, 1, 32'h0000_0042, exp_err);
    applyStimulus(0, 1, 0, 0, 2'd0, 16'h0042);
    tick();
    checkOutput("d_call_idle", 0, 0, 0, 16'h0000, 0, 0, 32'h0000_0042, exp_err);
    tick();
    checkOutput("d_ret_acc", 1, 0, 1, 16'h700A, 1, 0, 32'h0000_0042, exp_err);
    applyStimulus(0, 0, 0, 0, 2'd0, 16'h0042);
    tick();
    checkOutput("d_ret_lo", 0, 0, 1, 16'h700B, 1, 0, 32'h0000_0042, exp_err);
    tick();
    checkOutput("d_ret_idle", 0, 0, 0, 16'h0000, 0, 0, 32'h0000_0042, exp_err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
